// File: rtl/gpio_pad_pkg.sv
// ---------------------------------------------------------------------------
// gpio_pad_pkg
//
// Purpose:
//    Shared constants and helpers for the GPIO pad controller slice. It holds
//    the default bank geometry and the helper that sizes the settle and
//    warm-up counters.
//
// Contents:
//    GPIO_WIDTH          default number of pads in a bank
//    GPIO_SYNC_STAGES    default input synchronizer depth
//    GPIO_SETTLE_CYCLES  default extra cycles before readback is trusted
//    settle_cnt_width()  bits needed to hold SYNC_STAGES+SETTLE_CYCLES
// ---------------------------------------------------------------------------
package gpio_pad_pkg;

   localparam int GPIO_WIDTH         = 8;
   localparam int GPIO_SYNC_STAGES   = 2;
   localparam int GPIO_SETTLE_CYCLES = 2;

   // The settle counter reloads to SYNC_STAGES+SETTLE_CYCLES. The warm-up
   // counter starts at SYNC_STAGES+1, which is never larger because
   // SETTLE_CYCLES is at least 1. One counter width therefore covers both.
   function automatic int settle_cnt_width(input int sync_stages,
                                           input int settle_cycles);
      return $clog2(sync_stages + settle_cycles + 1);
   endfunction

endpackage

// File: rtl/gpio_sync_bit.sv
// ---------------------------------------------------------------------------
// gpio_sync_bit
//
// Purpose:
//    Single-bit multi-flop synchronizer. It brings an asynchronous pad input
//    into the core clock domain. Every stage clears to 0 on reset.
//
// Ports:
//    clk    in   core clock
//    rst_n  in   asynchronous active-low reset
//    d      in   asynchronous input bit
//    q      out  synchronized bit (output of the last stage)
// ---------------------------------------------------------------------------
module gpio_sync_bit
   import gpio_pad_pkg::*;
#(
   parameter int STAGES = GPIO_SYNC_STAGES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   // The shift chain is deliberately free of any logic between flops. This
   // gives a metastable first stage a full cycle to resolve.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= '0;
      end else begin
         chain <= {chain[STAGES-2:0], d};
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/gpio_pad_ctrl.sv
// ---------------------------------------------------------------------------
// gpio_pad_ctrl
//
// Purpose:
//    Core-side controller for a bank of bidirectional tristate pads.
//    - Registers the output data and output enable for each pad.
//    - Synchronizes the pad inputs into the HCLK domain.
//    - Detects rising and falling edges into sticky pending flags.
//    - Checks that each driven pad reads back the value being driven, and
//      records any bus conflict as a sticky flag.
//
// Ports:
//    HCLK        in   sole clock
//    HRESETn     in   asynchronous active-low reset
//    dout_we     in   load strobe for the output data register
//    dout_wdata  in   new output data
//    oe_we       in   load strobe for the output-enable register
//    oe_wdata    in   new output enables (1 = drive pad)
//    rise_en     in   per-bit rising-edge detect enable
//    fall_en     in   per-bit falling-edge detect enable
//    pend_clr    in   write-1-to-clear pulses for edge_pend
//    conf_clr    in   write-1-to-clear pulses for conflict
//    pad_o       out  pad output data
//    pad_oe      out  pad output enable
//    pad_i       in   raw pad input (asynchronous)
//    din         out  synchronized pad input
//    edge_pend   out  sticky edge-pending flags
//    irq         out  OR of edge_pend
//    conflict    out  sticky readback-mismatch flags
// ---------------------------------------------------------------------------
module gpio_pad_ctrl
   import gpio_pad_pkg::*;
#(
   parameter int WIDTH         = GPIO_WIDTH,
   parameter int SYNC_STAGES   = GPIO_SYNC_STAGES,
   parameter int SETTLE_CYCLES = GPIO_SETTLE_CYCLES
) (
   input  logic             HCLK,
   input  logic             HRESETn,
   input  logic             dout_we,
   input  logic [WIDTH-1:0] dout_wdata,
   input  logic             oe_we,
   input  logic [WIDTH-1:0] oe_wdata,
   input  logic [WIDTH-1:0] rise_en,
   input  logic [WIDTH-1:0] fall_en,
   input  logic [WIDTH-1:0] pend_clr,
   input  logic [WIDTH-1:0] conf_clr,
   output logic [WIDTH-1:0] pad_o,
   output logic [WIDTH-1:0] pad_oe,
   input  logic [WIDTH-1:0] pad_i,
   output logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] edge_pend,
   output logic             irq,
   output logic [WIDTH-1:0] conflict
);

   localparam int               CNT_W         = settle_cnt_width(SYNC_STAGES, SETTLE_CYCLES);
   localparam logic [CNT_W-1:0] SETTLE_RELOAD = CNT_W'(SYNC_STAGES + SETTLE_CYCLES);
   localparam logic [CNT_W-1:0] WARMUP_INIT   = CNT_W'(SYNC_STAGES + 1);
   localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

   logic             write_any;
   logic [WIDTH-1:0] din_prev;
   logic [CNT_W-1:0] settle_cnt;
   logic [CNT_W-1:0] warmup_cnt;
   logic [WIDTH-1:0] rise_det;
   logic [WIDTH-1:0] fall_det;
   logic [WIDTH-1:0] edge_det;
   logic             check_active;
   logic [WIDTH-1:0] conf_set;

   assign write_any = dout_we | oe_we;

   // Output data and enable registers. The two strobes are independent, so
   // a cycle that asserts both loads both registers.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         pad_o  <= '0;
         pad_oe <= '0;
      end else begin
         if (dout_we) begin
            pad_o <= dout_wdata;
         end
         if (oe_we) begin
            pad_oe <= oe_wdata;
         end
      end
   end

   // One synchronizer per pad. din is the last stage of each chain.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sync
      gpio_sync_bit #(
         .STAGES (SYNC_STAGES)
      ) u_sync (
         .clk   (HCLK),
         .rst_n (HRESETn),
         .d     (pad_i[gi]),
         .q     (din[gi])
      );
   end

   // Copy of din delayed by one cycle, used to spot transitions.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         din_prev <= '0;
      end else begin
         din_prev <= din;
      end
   end

   // Warm-up counter. Right after reset, the synchronizers fill with
   // whatever level the pads are sitting at. Without this counter, a pad
   // held high through reset would look like a rising edge. The counter
   // masks edge detection until the pipeline and din_prev have caught up.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         warmup_cnt <= WARMUP_INIT;
      end else if (warmup_cnt != '0) begin
         warmup_cnt <= warmup_cnt - CNT_ONE;
      end
   end

   // Settle counter. Any write to the drive registers restarts the window.
   // The pad needs time to change, and the synchronizer needs time to carry
   // the new level to din, before a readback mismatch means anything.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         settle_cnt <= '0;
      end else if (write_any) begin
         settle_cnt <= SETTLE_RELOAD;
      end else if (settle_cnt != '0) begin
         settle_cnt <= settle_cnt - CNT_ONE;
      end
   end

   // Combinational edge and conflict detection. A write in the current
   // cycle also blocks the check, because pad_o/pad_oe are about to change
   // under it.
   always_comb begin
      rise_det     = '0;
      fall_det     = '0;
      edge_det     = '0;
      check_active = 1'b0;
      conf_set     = '0;

      rise_det = din & ~din_prev & rise_en;
      fall_det = ~din & din_prev & fall_en;
      if (warmup_cnt == '0) begin
         edge_det = rise_det | fall_det;
      end

      check_active = (settle_cnt == '0) && !write_any;
      if (check_active) begin
         conf_set = pad_oe & (din ^ pad_o);
      end
   end

   // Sticky flags. A new event in the same cycle as a clear must not be
   // lost, so the set term is ORed in after the clear is applied.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         edge_pend <= '0;
         conflict  <= '0;
      end else begin
         edge_pend <= (edge_pend & ~pend_clr) | edge_det;
         conflict  <= (conflict & ~conf_clr) | conf_set;
      end
   end

   assign irq = |edge_pend;

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// ---------------------------------------------------------------------------
// tb_gpio_pad_ctrl
//
// Purpose:
//    Directed testbench for gpio_pad_ctrl (WIDTH=8, SYNC_STAGES=2,
//    SETTLE_CYCLES=2).
//
//    Pad model: each pad reads, in priority order,
//       1. the external driver, if ext_en is set for that pad;
//       2. otherwise its own output, if it is enabled;
//       3. otherwise the pull level.
//
//    Structure:
//       - A table of per-cycle vectors covers drive, readback and edges.
//       - Hand-written sequences cover reset, conflicts, clear races, settle
//         restart and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_gpio_pad_ctrl;

   logic       HCLK;
   logic       HRESETn;
   logic       dout_we;
   logic [7:0] dout_wdata;
   logic       oe_we;
   logic [7:0] oe_wdata;
   logic [7:0] rise_en;
   logic [7:0] fall_en;
   logic [7:0] pend_clr;
   logic [7:0] conf_clr;
   logic [7:0] pad_o;
   logic [7:0] pad_oe;
   logic [7:0] pad_i;
   logic [7:0] din;
   logic [7:0] edge_pend;
   logic       irq;
   logic [7:0] conflict;

   logic [7:0] ext_en;
   logic [7:0] ext_val;
   logic [7:0] pull_val;

   int n_vec;
   int n_miss;

   typedef struct {
      logic       dout_we;
      logic [7:0] dout_wdata;
      logic       oe_we;
      logic [7:0] oe_wdata;
      logic [7:0] pend_clr;
      logic [7:0] conf_clr;
      logic [7:0] exp_pad_o;
      logic [7:0] exp_pad_oe;
      logic [7:0] exp_din;
      logic [7:0] exp_ep;
      logic [7:0] exp_cf;
   } vec_t;

   vec_t vecs[16];

   gpio_pad_ctrl #(
      .WIDTH         (8),
      .SYNC_STAGES   (2),
      .SETTLE_CYCLES (2)
   ) dut (
      .HCLK       (HCLK),
      .HRESETn    (HRESETn),
      .dout_we    (dout_we),
      .dout_wdata (dout_wdata),
      .oe_we      (oe_we),
      .oe_wdata   (oe_wdata),
      .rise_en    (rise_en),
      .fall_en    (fall_en),
      .pend_clr   (pend_clr),
      .conf_clr   (conf_clr),
      .pad_o      (pad_o),
      .pad_oe     (pad_oe),
      .pad_i      (pad_i),
      .din        (din),
      .edge_pend  (edge_pend),
      .irq        (irq),
      .conflict   (conflict)
   );

   // Pad ring model
   assign pad_i = (ext_en & ext_val) | (~ext_en & pad_oe & pad_o) | (~ext_en & ~pad_oe & pull_val);

   // 100 MHz clock
   initial begin
      HCLK = 1'b0;
      forever #5 HCLK = ~HCLK;
   end

   // One comparison against a bench-computed expectation
   task automatic check_field(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Advance one clock and sample away from the edge
   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic idle_inputs();
      dout_we    = 1'b0;
      dout_wdata = 8'h00;
      oe_we      = 1'b0;
      oe_wdata   = 8'h00;
      pend_clr   = 8'h00;
      conf_clr   = 8'h00;
   endtask

   task automatic apply_stimulus(input vec_t v);
      dout_we    = v.dout_we;
      dout_wdata = v.dout_wdata;
      oe_we      = v.oe_we;
      oe_wdata   = v.oe_wdata;
      pend_clr   = v.pend_clr;
      conf_clr   = v.conf_clr;
   endtask

   task automatic check_output(input int idx, input vec_t v);
      check_field($sformatf("vec%0d pad_o", idx),     pad_o,           v.exp_pad_o);
      check_field($sformatf("vec%0d pad_oe", idx),    pad_oe,          v.exp_pad_oe);
      check_field($sformatf("vec%0d din", idx),       din,             v.exp_din);
      check_field($sformatf("vec%0d edge_pend", idx), edge_pend,       v.exp_ep);
      check_field($sformatf("vec%0d irq", idx),       {7'b0, irq},     {7'b0, |v.exp_ep});
      check_field($sformatf("vec%0d conflict", idx),  conflict,        v.exp_cf);
   endtask

   initial begin
      n_vec  = 0;
      n_miss = 0;

      // Vector table (rise_en=0F, fall_en=00, pads loop back, pull=0).
      // Fields: dout_we, dout_wdata, oe_we, oe_wdata, pend_clr, conf_clr,
      //         then expected pad_o, pad_oe, din, edge_pend, conflict.
      vecs[0]  = '{1'b1, 8'h05, 1'b1, 8'h0F, 8'h00, 8'h00, 8'h05, 8'h0F, 8'h00, 8'h00, 8'h00};
      vecs[1]  = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h05, 8'h0F, 8'h00, 8'h00, 8'h00};
      vecs[2]  = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h05, 8'h0F, 8'h05, 8'h00, 8'h00};
      vecs[3]  = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h05, 8'h0F, 8'h05, 8'h05, 8'h00};
      vecs[4]  = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h01, 8'h00, 8'h05, 8'h0F, 8'h05, 8'h04, 8'h00};
      vecs[5]  = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'hFF, 8'h05, 8'h0F, 8'h05, 8'h04, 8'h00};
      vecs[6]  = '{1'b1, 8'h0A, 1'b0, 8'h00, 8'h00, 8'h00, 8'h0A, 8'h0F, 8'h05, 8'h04, 8'h00};
      vecs[7]  = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h0A, 8'h0F, 8'h05, 8'h04, 8'h00};
      vecs[8]  = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h0A, 8'h0F, 8'h0A, 8'h04, 8'h00};
      vecs[9]  = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h0A, 8'h0F, 8'h0A, 8'h0E, 8'h00};
      vecs[10] = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h0E, 8'h00, 8'h0A, 8'h0F, 8'h0A, 8'h00, 8'h00};
      vecs[11] = '{1'b0, 8'h00, 1'b1, 8'hFF, 8'h00, 8'h00, 8'h0A, 8'hFF, 8'h0A, 8'h00, 8'h00};
      vecs[12] = '{1'b1, 8'hF0, 1'b1, 8'hF0, 8'h00, 8'h00, 8'hF0, 8'hF0, 8'h0A, 8'h00, 8'h00};
      vecs[13] = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'hF0, 8'hF0, 8'h0A, 8'h00, 8'h00};
      vecs[14] = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'hF0, 8'hF0, 8'hF0, 8'h00, 8'h00};
      vecs[15] = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'hF0, 8'hF0, 8'hF0, 8'h00, 8'h00};

      // Reset with all pads pulled high; warm-up must hide the fake rise
      idle_inputs();
      HRESETn  = 1'b0;
      ext_en   = 8'h00;
      ext_val  = 8'h00;
      pull_val = 8'hFF;
      rise_en  = 8'hFF;
      fall_en  = 8'hFF;
      @(negedge HCLK);
      @(negedge HCLK);
      HRESETn = 1'b1;
      #1;
      check_field("reset pad_o",    pad_o,     8'h00);
      check_field("reset pad_oe",   pad_oe,    8'h00);
      check_field("reset din",      din,       8'h00);
      check_field("reset edge",     edge_pend, 8'h00);
      check_field("reset conflict", conflict,  8'h00);
      for (int k = 1; k <= 5; k++) begin
         tick();
         check_field($sformatf("warmup%0d din", k), din, (k >= 2) ? 8'hFF : 8'h00);
         check_field($sformatf("warmup%0d edge", k), edge_pend, 8'h00);
         check_field($sformatf("warmup%0d irq", k), {7'b0, irq}, 8'h00);
      end

      // Fresh reset with pads low for the vector table
      HRESETn  = 1'b0;
      pull_val = 8'h00;
      rise_en  = 8'h0F;
      fall_en  = 8'h00;
      #2;
      HRESETn = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
      end

      for (int i = 0; i < 16; i++) begin
         apply_stimulus(vecs[i]);
         tick();
         check_output(i, vecs[i]);
      end
      idle_inputs();

      // Conflict: pad 0 driven high but held low externally
      rise_en    = 8'h00;
      ext_en     = 8'h01;
      ext_val    = 8'h00;
      oe_we      = 1'b1;
      oe_wdata   = 8'h01;
      dout_we    = 1'b1;
      dout_wdata = 8'h01;
      tick();
      idle_inputs();
      check_field("conf e0", conflict, 8'h00);
      for (int k = 1; k <= 4; k++) begin
         tick();
         check_field($sformatf("conf e%0d", k), conflict, 8'h00);
      end
      tick();
      check_field("conf e5", conflict, 8'h01);
      conf_clr = 8'h01;
      tick();
      conf_clr = 8'h00;
      check_field("conf set wins", conflict, 8'h01);
      ext_en = 8'h00;
      for (int k = 0; k < 3; k++) begin
         tick();
      end
      check_field("conf sticky", conflict, 8'h01);
      conf_clr = 8'h01;
      tick();
      conf_clr = 8'h00;
      check_field("conf cleared", conflict, 8'h00);

      // Edges: rise on pad 7 only
      rise_en = 8'h80;
      fall_en = 8'h00;
      ext_en  = 8'h80;
      ext_val = 8'h00;
      for (int k = 0; k < 3; k++) begin
         tick();
      end
      check_field("edge idle", edge_pend, 8'h00);
      ext_val = 8'h80;
      tick();
      tick();
      check_field("edge din", din, 8'h81);
      check_field("edge before", edge_pend, 8'h00);
      tick();
      check_field("edge rise", edge_pend, 8'h80);
      check_field("edge irq", {7'b0, irq}, 8'h01);
      ext_val = 8'h00;
      for (int k = 0; k < 3; k++) begin
         tick();
      end
      check_field("edge no fall", edge_pend, 8'h80);
      pend_clr = 8'h80;
      tick();
      pend_clr = 8'h00;
      check_field("edge clr", edge_pend, 8'h00);
      check_field("edge clr irq", {7'b0, irq}, 8'h00);

      // Rise on pad 2 in the same cycle as its clear
      rise_en = 8'h04;
      ext_en  = 8'h84;
      ext_val = 8'h00;
      for (int k = 0; k < 3; k++) begin
         tick();
      end
      ext_val = 8'h04;
      tick();
      tick();
      pend_clr = 8'h04;
      tick();
      pend_clr = 8'h00;
      check_field("race set wins", edge_pend, 8'h04);
      pend_clr = 8'h04;
      tick();
      pend_clr = 8'h00;
      check_field("race clr", edge_pend, 8'h00);

      // Rewrite during settle window restarts the counter
      ext_en     = 8'h85;
      ext_val    = 8'h04;
      dout_we    = 1'b1;
      dout_wdata = 8'h01;
      tick();
      idle_inputs();
      tick();
      tick();
      dout_we    = 1'b1;
      dout_wdata = 8'h01;
      tick();
      idle_inputs();
      check_field("settle r0", conflict, 8'h00);
      for (int k = 1; k <= 4; k++) begin
         tick();
         check_field($sformatf("settle r%0d", k), conflict, 8'h00);
      end
      tick();
      check_field("settle r5", conflict, 8'h01);

      // Asynchronous reset mid-cycle while all pads drive
      oe_we      = 1'b1;
      oe_wdata   = 8'hFF;
      dout_we    = 1'b1;
      dout_wdata = 8'h00;
      tick();
      idle_inputs();
      check_field("pre-rst pad_oe", pad_oe, 8'hFF);
      #2;
      HRESETn = 1'b0;
      #1;
      check_field("async pad_oe",   pad_oe,      8'h00);
      check_field("async pad_o",    pad_o,       8'h00);
      check_field("async din",      din,         8'h00);
      check_field("async edge",     edge_pend,   8'h00);
      check_field("async irq",      {7'b0, irq}, 8'h00);
      check_field("async conflict", conflict,    8'h00);
      #3;
      HRESETn = 1'b1;
      tick();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/gpio_pad_ctrl.md
# gpio_pad_ctrl

Core-side controller for a bank of generic bidirectional tristate pads (PAD_INOUT8MA_OE cells): it registers output data and output-enable for each pad, brings the pad input back into the HCLK domain through a synchronizer, and detects rising and falling edges. It also checks that each enabled pad actually reads back the value being driven, flagging bus conflicts as sticky status. It sits between the SoC GPIO register block and the pad ring.

## Interface
Parameters:
- WIDTH, 8: number of pads in the bank.
- SYNC_STAGES, 2: input synchronizer depth (≥2).
- SETTLE_CYCLES, 2: extra HCLK cycles after a drive change before readback is checked (≥1).

Ports:
- HCLK  in  1  sole clock.
- HRESETn  in  1  asynchronous, active-low reset.
- dout_we  in  1  write strobe for the output data register.
- dout_wdata  in  WIDTH  new output data.
- oe_we  in  1  write strobe for the output-enable register.
- oe_wdata  in  WIDTH  new output enables (1 = drive pad).
- rise_en  in  WIDTH  per-bit rising-edge detect enable (static config).
- fall_en  in  WIDTH  per-bit falling-edge detect enable.
- pend_clr  in  WIDTH  write-1-to-clear for edge_pend, single-cycle.
- conf_clr  in  WIDTH  write-1-to-clear for conflict, single-cycle.
- pad_o  out  WIDTH  to pad O.
- pad_oe  out  WIDTH  to pad OE.
- pad_i  in  WIDTH  from pad I (asynchronous).
- din  out  WIDTH  synchronized pad input.
- edge_pend  out  WIDTH  sticky edge-pending flags.
- irq  out  1  OR of edge_pend.
- conflict  out  WIDTH  sticky readback-mismatch flags.

## Operation
- Reset: pad_o=0, pad_oe=0 (all pads tristate), din=0, edge_pend=0, irq=0, conflict=0, settle counter=0, warm-up counter=SYNC_STAGES+1.
- dout_we/oe_we load their registers; both strobes together in one cycle both take effect.
- Synchronizer: SYNC_STAGES flops per bit; din is the last stage; din_prev holds din from the previous cycle.
- Edge detect: rise = din & ~din_prev & rise_en; fall = ~din & din_prev & fall_en. Suppressed while warm-up counter ≠ 0; the counter decrements every cycle to 0 after reset and then stays there.
- edge_pend[i]: set by a detected edge, cleared by pend_clr[i]; set wins when both occur in the same cycle.
- Settle counter: any cycle with dout_we or oe_we reloads it to SYNC_STAGES+SETTLE_CYCLES; otherwise it decrements toward 0.
- Readback check: active when the counter = 0 and there is no write this cycle. For each bit with pad_oe[i]=1 and din[i]≠pad_o[i], conflict[i] is set. Bits with oe=0 are never flagged.
- conflict[i] is cleared by conf_clr[i]; set wins over clear.

## Timing
- A write in cycle N appears on pad_o/pad_oe at the HCLK edge ending cycle N (1-cycle latency).
- A pad_i change is visible on din SYNC_STAGES edges later. edge_pend and irq assert 1 edge after the din change.
- The earliest conflict flag is SYNC_STAGES+SETTLE_CYCLES+1 edges after the last write.
- An asynchronous reset mid-operation immediately tristates all pads and clears all state; the warm-up counter restarts.
- irq is combinational from the edge_pend registers.

## Structure
- Shared package gpio_pad_pkg holds the default constants (GPIO_WIDTH=8, GPIO_SYNC_STAGES=2, GPIO_SETTLE_CYCLES=2) and the settle-counter width function (clog2 of SYNC_STAGES+SETTLE_CYCLES+1).
- One sub-module, gpio_sync_bit: a single-bit SYNC_STAGES-deep synchronizer with async active-low reset, instantiated WIDTH times.
- Edge, settle and conflict logic stays in the top module.

## Test plan
- Reset: with pad_i=8'hFF held through reset, after release pad_oe=0, pad_o=0 and no edge_pend sets during warm-up; din=8'hFF after SYNC_STAGES+1 cycles.
- Drive/readback: write oe=8'h0F, dout=8'h05 with a loopback pad model → pad_o=8'h05 next cycle, din=8'h05 after 3 cycles, conflict stays 8'h00 indefinitely.
- Conflict: oe=8'h01, dout=8'h01, external driver forces the pad to 0 → conflict=8'h01 exactly 5 edges after the write. conf_clr=8'h01 while the fault persists keeps the flag at 1 (set wins); the flag clears after the fault is removed.
- Edges: rise_en=8'h80, fall_en=8'h00; toggle pad_i[7] 0→1→0 → edge_pend=8'h80 and irq=1 on the rise only. pend_clr=8'h80 → 0 the next cycle.
- Simultaneous events: a rise on bit 2 in the same cycle as pend_clr[2] → edge_pend[2] remains 1. A write during the settle window restarts the counter, so no conflict is flagged within 4 cycles of the rewrite.
- Mid-operation reset: assert HRESETn low while oe=8'hFF → pad_oe=0 asynchronously, before the next HCLK edge; all flags read 0.
